ab_debouncer: RTL and testbench

AB_DEBOUNCER -- requirements
Module: ab_debouncer

---
 rtl/ab_debouncer_pkg.sv | 20 ++
 rtl/debounce_ch.sv | 119 +++++++++++
 rtl/ab_debouncer.sv | 45 ++++
 tb/tb_ab_debouncer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ab_debouncer_pkg.sv
// Shared types and default sizing for the A/B debouncer.
package ab_debouncer_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      WAIT_HIGH   = 2'b01,
      STABLE_HIGH = 2'b10,
      WAIT_LOW    = 2'b11
   } db_state_e;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   // Clean level implied by a state: high while settled high or while
   // still deciding whether a high level is really going away.
   function automatic logic state_is_high(input db_state_e st);
      return (st == STABLE_HIGH) || (st == WAIT_LOW);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: raw pad synchronizer, accept/reject FSM with a
// consecutive-sample counter, and registered clean level plus edge pulses.
//
// state       | meaning
// ------------+-------------------------------------------------------
// STABLE_LOW  | clean = 0, synchronized sample agrees
// WAIT_HIGH   | clean = 0, sample went high, counting high samples
// STABLE_HIGH | clean = 1, synchronized sample agrees
// WAIT_LOW    | clean = 1, sample went low, counting low samples
module debounce_ch
   import ab_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("debounce_ch: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   db_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Shift the asynchronous pad level through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   // Next state, counter and output decode; a level change is accepted only
   // after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         STABLE_LOW: begin
            if (s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (s) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
         end
      endcase
      clean_d = state_is_high(state_d);
      rise_d  = clean_d & ~clean_q;
      fall_d  = ~clean_d & clean_q;
   end

   // FSM, counter and registered outputs; reset drops any pending change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign clean = clean_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ab_debouncer.sv
// Two independent debounce channels for the A and B operands feeding the
// downstream AND stage.
module ab_debouncer
   import ab_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_raw,
   input  logic b_raw,
   output logic a_clean,
   output logic b_clean,
   output logic a_rise,
   output logic b_rise,
   output logic a_fall,
   output logic b_fall
);

   debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_ch_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (a_raw),
      .clean (a_clean),
      .rise  (a_rise),
      .fall  (a_fall)
   );

   debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_ch_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (b_raw),
      .clean (b_clean),
      .rise  (b_rise),
      .fall  (b_fall)
   );

endmodule

// File: tb/tb_ab_debouncer.sv
// Directed bench for ab_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge, so the next edge is the
// first one to sample them. A clean change lands on the 6th edge counting
// that sampling edge as the 1st, i.e. it is visible after the 6th tick().
module tb_ab_debouncer;

   logic clk = 1'b0;
   logic rst_n;
   logic a_raw, b_raw;
   logic a_clean, b_clean, a_rise, b_rise, a_fall, b_fall;

   int tests  = 0;
   int failed = 0;

   ab_debouncer #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_raw   (a_raw),
      .b_raw   (b_raw),
      .a_clean (a_clean),
      .b_clean (b_clean),
      .a_rise  (a_rise),
      .b_rise  (b_rise),
      .a_fall  (a_fall),
      .b_fall  (b_fall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag,
                          input logic ac, input logic ar, input logic af,
                          input logic bc, input logic br, input logic bf);
      chk({tag, ".a_clean"}, a_clean, ac);
      chk({tag, ".a_rise"},  a_rise,  ar);
      chk({tag, ".a_fall"},  a_fall,  af);
      chk({tag, ".b_clean"}, b_clean, bc);
      chk({tag, ".b_rise"},  b_rise,  br);
      chk({tag, ".b_fall"},  b_fall,  bf);
   endtask

   initial begin
      rst_n = 1'b0;
      a_raw = 1'b0;
      b_raw = 1'b0;

      // reset state
      #2;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk_all("post_reset_idle", 0, 0, 0, 0, 0, 0);

      // A steps high and holds: rise on the 6th edge, B untouched
      a_raw = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_all("step_a", k >= 6, k == 6, 0, 0, 0, 0);
      end

      // return A low: fall on the 6th edge
      a_raw = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_all("release_a", k < 6, 0, k == 6, 0, 0, 0);
      end

      // 3-cycle glitch is one sample short: rejected
      a_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) a_raw = 1'b0;
         tick();
         chk_all("short_pulse", 0, 0, 0, 0, 0, 0);
      end

      // bounce 1,0,1,0 then hold 1: one rise, 6 edges after the last 0->1
      a_raw = 1'b1; tick(); chk_all("bounce", 0, 0, 0, 0, 0, 0);
      a_raw = 1'b0; tick(); chk_all("bounce", 0, 0, 0, 0, 0, 0);
      a_raw = 1'b1; tick(); chk_all("bounce", 0, 0, 0, 0, 0, 0);
      a_raw = 1'b0; tick(); chk_all("bounce", 0, 0, 0, 0, 0, 0);
      a_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_all("bounce_hold", k >= 6, k == 6, 0, 0, 0, 0);
      end
      a_raw = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      chk_all("bounce_settle", 0, 0, 0, 0, 0, 0);

      // A and B rise together, then release together
      a_raw = 1'b1;
      b_raw = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_all("both_rise", k >= 6, k == 6, 0, k >= 6, k == 6, 0);
         chk("both_rise.and", a_clean & b_clean, k >= 6);
      end
      a_raw = 1'b0;
      b_raw = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_all("both_fall", k < 6, 0, k == 6, k < 6, 0, k == 6);
      end

      // reset 2 cycles into WAIT_HIGH, raw stays high across reset
      a_raw = 1'b1;
      tick();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_all("mid_wait_reset", 0, 0, 0, 0, 0, 0);
      tick();
      chk_all("mid_wait_reset_hold", 0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_all("post_reset_rise", k >= 6, k == 6, 0, 0, 0, 0);
      end

      // A low for exactly 4 samples is accepted; back high re-rises later
      a_raw = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         if (k == 5) a_raw = 1'b1;
         tick();
         chk_all("min_fall", (k < 6) || (k >= 10), k == 10, k == 6, 0, 0, 0);
      end

      // asynchronous reset clears a high clean level without a clock edge
      tick();
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0, 0);
      tick();
      chk_all("async_reset_hold", 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
